// File: rtl/fifo_block_writer.sv
// FIFO write-side block source: on start, pushes len words (incrementing count or Galois LFSR
// sequence from a seed) into a FIFO write port, stalling while full is high.
module fifo_block_writer #(
    parameter int                 WIDTH          = 8,
    parameter int                 MAX_BLOCK_SIZE = 1024,
    parameter logic [WIDTH-1:0]   POLY           = 8'hB8,
    parameter int                 LEN_W          = $clog2(MAX_BLOCK_SIZE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] seed,
    input  logic             mode,
    output logic [WIDTH-1:0] dout,
    output logic             wren,
    input  logic             full,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BLOCK_SIZE);
    localparam logic [LEN_W-1:0] ONE_LEN  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_WORD = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             mode_q, mode_d;
    logic             wren_s;

    // Next data word: +1 wrapping, or right-shifting Galois LFSR with feedback mask POLY.
    function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] cur, input logic m);
        logic [WIDTH-1:0] nxt;
        if (m) begin
            nxt = (cur >> 1) ^ (cur[0] ? POLY : {WIDTH{1'b0}});
        end else begin
            nxt = cur + ONE_WORD;
        end
        return nxt;
    endfunction

    assign wren_s = (state_q == WRITE) && !full;

    // Next-state and datapath update for the block sequencer.
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        count_d = count_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = {LEN_W{1'b0}};
                    mode_d  = mode;
                    // All-zero is the LFSR lock-up state, so an LFSR seed of zero becomes one.
                    dout_d  = (mode && (seed == {WIDTH{1'b0}})) ? ONE_WORD : seed;
                    rem_d   = (len > MAX_LEN) ? MAX_LEN : len;
                    state_d = (len == {LEN_W{1'b0}}) ? DONE : WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (wren_s) begin
                    dout_d  = next_word(dout_q, mode_q);
                    count_d = count_q + ONE_LEN;
                    rem_d   = rem_q - ONE_LEN;
                    state_d = (rem_q == ONE_LEN) ? DONE : WRITE;
                end else begin
                    state_d = WRITE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dout_q  <= {WIDTH{1'b0}};
            count_q <= {LEN_W{1'b0}};
            rem_q   <= {LEN_W{1'b0}};
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign dout  = dout_q;
    assign count = count_q;
    assign wren  = wren_s;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_fifo_block_writer.sv
// Directed bench for fifo_block_writer: expected words are queued at start and popped on wren.
module tb_fifo_block_writer;

    localparam int LW = 11;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          mode  = 1'b0;
    logic          full  = 1'b0;
    logic [LW-1:0] len   = '0;
    logic [7:0]    seed  = 8'h00;
    logic [7:0]    dout;
    logic          wren;
    logic          busy;
    logic          done;
    logic [LW-1:0] count;

    int         total = 0;
    int         bad   = 0;
    int         writes = 0;
    bit         done_seen;
    logic       busy_at;
    logic [LW-1:0] count_at;
    logic [7:0] expq[$];

    always #5 clk = ~clk;

    fifo_block_writer dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .len   (len),
        .seed  (seed),
        .mode  (mode),
        .dout  (dout),
        .wren  (wren),
        .full  (full),
        .busy  (busy),
        .done  (done),
        .count (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_next(input logic [7:0] v, input logic m);
        if (m) return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
        return v + 8'd1;
    endfunction

    // Sample at the falling edge, then advance to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        done_seen = (done === 1'b1);
        busy_at   = busy;
        count_at  = count;
        if (full === 1'b1) check("wren_while_full", {31'd0, wren}, 32'd0);
        if (wren === 1'b1) begin
            writes++;
            check("write_expected", {31'd0, expq.size() > 0}, 32'd1);
            if (expq.size() > 0) check("dout", {24'd0, dout}, {24'd0, expq.pop_front()});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input int l, input logic [7:0] s, input logic m, output int n);
        logic [7:0] v;
        check("queue_empty_at_start", expq.size(), 32'd0);
        n = (l > 1024) ? 1024 : l;
        v = (m && s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < n; i++) begin
            expq.push_back(v);
            v = model_next(v, m);
        end
        writes = 0;
        start = 1'b1; len = l[LW-1:0]; seed = s; mode = m; full = 1'b0;
        step();
        start = 1'b0; len = 11'd5; seed = 8'h33; mode = ~m;
    endtask

    task automatic wait_done(input int n, input int exp_cyc, input logic [31:0] full_pat,
                             input logic [31:0] poke);
        int k;
        done_seen = 1'b0;
        for (k = 0; k < exp_cyc + 20; k++) begin
            full  = (k < 32) ? full_pat[k] : 1'b0;
            start = (k < 32) ? poke[k] : 1'b0;
            if (start) begin len = 11'd7; seed = 8'hAA; end
            step();
            if (done_seen) break;
        end
        start = 1'b0; full = 1'b0;
        check("done_seen", {31'd0, done_seen}, 32'd1);
        check("cycles_to_done", k, exp_cyc);
        check("busy_with_done", {31'd0, busy_at}, 32'd1);
        check("count_at_done", {21'd0, count_at}, n);
        check("writes", writes, n);
        check("queue_drained", expq.size(), 32'd0);
        step();
        check("done_one_cycle", {31'd0, done_seen}, 32'd0);
        check("idle_after_done", {31'd0, busy_at}, 32'd0);
        check("count_held", {21'd0, count_at}, n);
    endtask

    initial begin
        int n;
        #1;
        check("rst_wren", {31'd0, wren}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {21'd0, count}, 32'd0);
        check("rst_dout", {24'd0, dout}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // Increment mode with wrap: FE, FF, 00, 01.
        start_block(4, 8'hFE, 1'b0, n);
        wait_done(n, 4, 32'h0, 32'h0);

        // LFSR mode, normal seed and zero seed.
        start_block(3, 8'h01, 1'b1, n);
        wait_done(n, 3, 32'h0, 32'h0);
        start_block(2, 8'h00, 1'b1, n);
        wait_done(n, 2, 32'h0, 32'h0);

        // Backpressure on WRITE cycles 2-4, then full toggling every cycle.
        start_block(6, 8'h20, 1'b0, n);
        wait_done(n, 9, 32'h0000_000E, 32'h0);
        start_block(4, 8'h5A, 1'b1, n);
        wait_done(n, 8, 32'h5555_5555, 32'h0);

        // Zero length and clamped length.
        start_block(0, 8'h11, 1'b0, n);
        wait_done(n, 0, 32'h0, 32'h0);
        start_block(2000, 8'h00, 1'b0, n);
        wait_done(n, 1024, 32'h0, 32'h0);

        // Start pulses during WRITE and during DONE are ignored.
        start_block(3, 8'h80, 1'b0, n);
        wait_done(n, 3, 32'h0, 32'h0000_0009);
        start_block(2, 8'h07, 1'b1, n);
        wait_done(n, 2, 32'h0, 32'h0);

        // Reset after 3 of 8 writes aborts the block immediately.
        start_block(8, 8'h10, 1'b1, n);
        step(); step(); step();
        check("writes_before_rst", writes, 32'd3);
        check("wren_before_rst", {31'd0, wren}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_wren", {31'd0, wren}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_count", {21'd0, count}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_unwritten", expq.size(), 32'd5);
        expq.delete();
        step(); step();
        check("writes_during_rst", writes, 32'd3);
        rst = 1'b0;
        step();
        check("no_done_after_abort", {31'd0, done_seen}, 32'd0);
        start_block(8, 8'hC3, 1'b0, n);
        wait_done(n, 8, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
